// File: rtl/stopwatch_ctrl.sv
// Purpose : MM:SS stopwatch with pause toggle, per-field adjust mode and
//           display-multiplex (fast) / adjust-blink (blink) square waves.
// Latency : every output is a register; inputs take effect on the next clk edge.
// Backpr. : none -- pause is a one-cycle pulse, adj/sel are levels.
// Ports   : clk, reset (async, active-high); pause, adj, sel inputs;
//           min1/min2/sec1/sec2 BCD digits, fast, blink outputs.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 100000000,
  parameter int ADJ_DIV   = 50000000,
  parameter int FAST_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  output logic [2:0] min1,
  output logic [3:0] min2,
  output logic [2:0] sec1,
  output logic [3:0] sec2,
  output logic       fast,
  output logic       blink
);

  localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int AW = (ADJ_DIV   > 1) ? $clog2(ADJ_DIV)   : 1;
  localparam int FW = (FAST_DIV  > 1) ? $clog2(FAST_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ADJ_LAST   = AW'(ADJ_DIV - 1);
  localparam logic [FW-1:0] FAST_LAST  = FW'(FAST_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    ADJUST = 2'd2
  } state_e;

  state_e        mode;
  logic          paused_q;
  logic [TW-1:0] tick_q;
  logic [AW-1:0] adj_div_q;
  logic [FW-1:0] fast_div_q;
  logic [BW-1:0] blink_div_q;

  logic [6:0]    sec_inc_d;
  logic [6:0]    min_inc_d;
  logic          sec_wrap;

  // Increment a {tens[2:0], units[3:0]} BCD field, wrapping 59 -> 00.
  function automatic logic [6:0] bcd59_inc(input logic [6:0] f);
    logic [6:0] r;
    if (f[3:0] == 4'd9) begin
      if (f[6:4] == 3'd5) r = 7'd0;
      else                r = {f[6:4] + 3'd1, 4'd0};
    end else begin
      r = {f[6:4], f[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Mode is a pure function of the adj level and the paused flag; it only
  // steers register updates, so no input reaches an output combinationally.
  always_comb begin
    mode = RUN;
    if (adj)           mode = ADJUST;
    else if (paused_q) mode = PAUSED;
  end

  always_comb begin
    sec_inc_d = bcd59_inc({sec1, sec2});
    min_inc_d = bcd59_inc({min1, min2});
    sec_wrap  = ({sec1, sec2} == {3'd5, 4'd9});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      paused_q    <= 1'b0;
      tick_q      <= '0;
      adj_div_q   <= '0;
      fast_div_q  <= '0;
      blink_div_q <= '0;
      min1        <= '0;
      min2        <= '0;
      sec1        <= '0;
      sec2        <= '0;
      fast        <= 1'b0;
      blink       <= 1'b0;
    end else begin
      // Pause toggles in every mode; a tick on the same edge still lands
      // because this edge's mode was decided by the old flag.
      if (pause) paused_q <= ~paused_q;

      if (fast_div_q == FAST_LAST) begin
        fast_div_q <= '0;
        fast       <= ~fast;
      end else begin
        fast_div_q <= fast_div_q + FW'(1);
      end

      case (mode)
        ADJUST: begin
          // Adjust divider sits at 0 outside ADJUST, so the first bump
          // lands ADJ_DIV edges after adj rises. tick_q is held.
          if (adj_div_q == ADJ_LAST) begin
            adj_div_q <= '0;
            if (sel) {sec1, sec2} <= sec_inc_d;
            else     {min1, min2} <= min_inc_d;
          end else begin
            adj_div_q <= adj_div_q + AW'(1);
          end
          if (blink_div_q == BLINK_LAST) begin
            blink_div_q <= '0;
            blink       <= ~blink;
          end else begin
            blink_div_q <= blink_div_q + BW'(1);
          end
        end
        RUN: begin
          adj_div_q   <= '0;
          blink_div_q <= '0;
          blink       <= 1'b0;
          if (tick_q == TICK_LAST) begin
            tick_q       <= '0;
            {sec1, sec2} <= sec_inc_d;
            if (sec_wrap) {min1, min2} <= min_inc_d;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        default: begin
          // PAUSED: time and tick divider frozen.
          adj_div_q   <= '0;
          blink_div_q <= '0;
          blink       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clk cycles per 1 Hz count tick.
REQ-002 SHALL have parameter ADJ_DIV, default 50000000, clk cycles per adjust increment (2 Hz).
REQ-003 SHALL have parameter FAST_DIV, default 100000, clk cycles per half-period of fast.
REQ-004 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per half-period of blink.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port pause  in  1  debounced one-cycle pulse; toggles the paused flag.
REQ-008 SHALL have port adj  in  1  level; 1 = adjust mode.
REQ-009 SHALL have port sel  in  1  level; adjust target: 0 = minutes, 1 = seconds.
REQ-010 SHALL have port min1  out  3  minutes tens digit, 0-5.
REQ-011 SHALL have port min2  out  4  minutes units digit, 0-9.
REQ-012 SHALL have port sec1  out  3  seconds tens digit, 0-5.
REQ-013 SHALL have port sec2  out  4  seconds units digit, 0-9.
REQ-014 SHALL have port fast  out  1  display-multiplex square wave for the seven-segment driver.
REQ-015 SHALL have port blink  out  1  adjust-blink square wave for the seven-segment driver.

Function
REQ-016 SHALL implement states RUN, PAUSED, ADJUST: ADJUST when adj=1; otherwise RUN if paused flag=0, else PAUSED.
REQ-017 SHALL toggle the paused flag on every cycle with pause=1, in all states, including ADJUST.
REQ-018 SHALL, in RUN, increment tick divider each cycle; at TICK_DIV-1, clear it and advance time by one second in the same edge.
REQ-019 SHALL hold (not clear) the tick divider in PAUSED and ADJUST.
REQ-020 SHALL advance time BCD-wise: sec2 9->0 carries sec1; sec1 5->0 carries min2; min2 9->0 carries min1; 59:59 -> 00:00.
REQ-021 SHALL clear the adjust divider on entry to ADJUST, so the first increment occurs ADJ_DIV cycles after adj rises.
REQ-022 SHALL, in ADJUST, increment the selected field (min1:min2 or sec1:sec2) by one at each ADJ_DIV-1 terminal count; field wraps 59->00 with no carry into the other field.
REQ-023 SHALL leave the unselected field unchanged in ADJUST; a change of sel mid-adjust takes effect on the next increment, and the divider keeps running.
REQ-024 SHALL, on adj falling, return to RUN or PAUSED per the paused flag, resuming the tick divider from its held value.
REQ-025 SHALL apply a tick coinciding with a pause pulse before pausing (time advances, then PAUSED).
REQ-026 SHALL toggle fast every FAST_DIV cycles, free-running in all states.
REQ-027 SHALL toggle blink every BLINK_DIV cycles while in ADJUST; blink SHALL be 0 and its divider cleared outside ADJUST.
REQ-028 SHALL drive all outputs directly from registers; no combinational paths from inputs to outputs.

Reset
REQ-029 SHALL, while reset=1, asynchronously force all digits 0, fast 0, blink 0, paused flag 0, and all dividers 0; state RUN after release.
REQ-030 SHALL, on reset asserted mid-operation (any state), discard the in-progress count and restart from 00:00 on the first edge after release.

Verification (TICK_DIV=10, ADJ_DIV=4, FAST_DIV=2, BLINK_DIV=3)
REQ-031 Release reset, run 600 cycles -> 01:00 (min2=1, others 0); fast toggles every 2 cycles; blink stays 0.
REQ-032 Preload 59:59 via adjust, run 10 cycles in RUN -> 00:00, no stray carry.
REQ-033 Pause pulse at cycle 35, hold 100 cycles -> display frozen at 00:03; second pulse -> 00:04 exactly 5 cycles later (divider held at 5).
REQ-034 adj=1, sel=1 from 00:58 for 12 cycles -> 00:59, 00:00, 00:01 at cycles 4/8/12; minutes unchanged; blink toggles every 3 cycles; blink=0 after adj falls.
REQ-035 Pause pulse on the same cycle as a terminal tick at 00:06 -> shows 00:07, then PAUSED.
REQ-036 Assert reset for 1 cycle while in ADJUST at 12:34 -> all outputs 0 immediately (asynchronously); after release, RUN, 00:01 after 10 cycles.
